// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Receives a framed program over a byte stream, writes each 16-bit
//            word to code memory and releases the processor on a good checksum.
// Revision : 1.0  initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              code_w_en,
    output logic [ADDR_W-1:0] code_addr_in,
    output logic [15:0]       code_in,
    output logic              run,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CNT_HI = 4'd1,
        S_CNT_LO = 4'd2,
        S_DAT_HI = 4'd3,
        S_DAT_LO = 4'd4,
        S_WRITE  = 4'd5,
        S_CHECK  = 4'd6,
        S_RUN    = 4'd7,
        S_ERROR  = 4'd8
    } state_t;

    localparam int unsigned c_max_words = 32'd1 << ADDR_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_addr;
    logic [15:0]       r_count;
    logic [15:0]       r_data;
    logic [7:0]        r_csum;

    logic              w_rx_state;
    logic              w_xfer;
    logic [15:0]       w_count_full;
    logic              w_count_ok;
    logic [ADDR_W:0]   w_addr_inc;
    logic              w_last_word;

    assign w_rx_state = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                        (r_state == S_DAT_HI) || (r_state == S_DAT_LO) ||
                        (r_state == S_CHECK);

    // A restart or reset cycle never consumes a byte.
    assign rx_ready     = w_rx_state && !load_start && !rst;
    assign w_xfer       = rx_valid && rx_ready;
    assign code_w_en    = (r_state == S_WRITE) && !rst;
    assign code_addr_in = r_addr[ADDR_W-1:0];
    assign code_in      = r_data;
    assign run          = (r_state == S_RUN);
    assign err          = (r_state == S_ERROR);

    assign w_count_full = {r_count[15:8], rx_data};
    assign w_count_ok   = (w_count_full != 16'd0) &&
                          (32'(w_count_full) <= c_max_words);
    assign w_addr_inc   = r_addr + 1'b1;
    assign w_last_word  = (32'(w_addr_inc) == 32'(r_count));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (load_start) begin
            w_state_nxt = S_CNT_HI;
        end else begin
            case (r_state)
                S_CNT_HI: if (w_xfer) w_state_nxt = S_CNT_LO;
                S_CNT_LO: if (w_xfer) w_state_nxt = w_count_ok ? S_DAT_HI : S_ERROR;
                S_DAT_HI: if (w_xfer) w_state_nxt = S_DAT_LO;
                S_DAT_LO: if (w_xfer) w_state_nxt = S_WRITE;
                S_WRITE:  w_state_nxt = w_last_word ? S_CHECK : S_DAT_HI;
                S_CHECK:  if (w_xfer) w_state_nxt = (rx_data == r_csum) ? S_RUN : S_ERROR;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_csum  <= '0;
        end else if (load_start) begin
            r_addr <= '0;
            r_csum <= '0;
        end else begin
            case (r_state)
                S_CNT_HI: if (w_xfer) begin
                    r_count[15:8] <= rx_data;
                    r_csum        <= r_csum ^ rx_data;
                end
                S_CNT_LO: if (w_xfer) begin
                    r_count[7:0] <= rx_data;
                    r_csum       <= r_csum ^ rx_data;
                end
                S_DAT_HI: if (w_xfer) begin
                    r_data[15:8] <= rx_data;
                    r_csum       <= r_csum ^ rx_data;
                end
                S_DAT_LO: if (w_xfer) begin
                    r_data[7:0] <= rx_data;
                    r_csum      <= r_csum ^ rx_data;
                end
                S_WRITE:  r_addr <= w_addr_inc;
                default:  ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Scoreboard bench for program_loader: expected writes are queued
//            by the stimulus and consumed by a monitor on each code_w_en.
// Revision : 1.0  initial release
// ============================================================================
module tb_program_loader;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              code_w_en;
    logic [ADDR_W-1:0] code_addr_in;
    logic [15:0]       code_in;
    logic              run;
    logic              err;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] words [0:511];
    int          n_checks = 0;
    int          n_fail   = 0;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .code_w_en(code_w_en), .code_addr_in(code_addr_in), .code_in(code_in),
        .run(run), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (code_w_en && !rst) begin
            wr_t e;
            check("ready_low_in_write", 32'(rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", 32'(code_addr_in), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(code_addr_in), 32'(e.addr));
                check("write_data", 32'(code_in), 32'(e.data));
            end
        end
    end

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    // Presents one byte and holds it until a transfer edge is seen.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        int budget;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        budget   = 0;
        do begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk); #1;
            budget++;
        end while (!ok && budget < 200);
        if (!ok) check("byte_accept_timeout", 32'(budget), 32'd0);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Sends a whole frame from words[]; illegal counts stop after the count bytes.
    task automatic load_frame(input logic [15:0] cnt, input logic [7:0] csum_flip, input bit gaps);
        logic [7:0] cs;
        bit legal;
        legal = (cnt >= 16'd1) && (cnt <= 16'd512);
        cs = cnt[15:8] ^ cnt[7:0];
        pulse_start();
        if (legal) begin
            for (int i = 0; i < int'(cnt); i++) begin
                exp_q.push_back('{addr: ADDR_W'(i), data: words[i]});
                cs = cs ^ words[i][15:8] ^ words[i][7:0];
            end
        end
        send_byte(cnt[15:8], gaps);
        send_byte(cnt[7:0], gaps);
        if (legal) begin
            for (int i = 0; i < int'(cnt); i++) begin
                send_byte(words[i][15:8], gaps);
                send_byte(words[i][7:0], gaps);
            end
            send_byte(cs ^ csum_flip, gaps);
        end
    endtask

    task automatic check_status(input string name, input logic exp_run, input logic exp_err);
        @(negedge clk);
        check({name, "_run"}, 32'(run), 32'(exp_run));
        check({name, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ready", 32'(rx_ready), 32'd0);
        check("reset_wen",   32'(code_w_en), 32'd0);
        check("reset_run",   32'(run), 32'd0);
        check("reset_err",   32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Good two-word load: 00 02 12 34 AB CD 42.
        words[0] = 16'h1234; words[1] = 16'hABCD;
        load_frame(16'd2, 8'h00, 1'b0);
        check_status("good", 1'b1, 1'b0);

        // Same frame, final byte 43.
        load_frame(16'd2, 8'h01, 1'b0);
        check_status("badsum", 1'b0, 1'b1);

        // Illegal counts: zero and 513.
        load_frame(16'h0000, 8'h00, 1'b0);
        check_status("cnt_zero", 1'b0, 1'b1);
        load_frame(16'h0201, 8'h00, 1'b0);
        check_status("cnt_513", 1'b0, 1'b1);

        // Three words with random gaps in rx_valid.
        words[0] = 16'h0102; words[1] = 16'hFEDC; words[2] = 16'h8000;
        load_frame(16'd3, 8'h00, 1'b1);
        check_status("backpressure", 1'b1, 1'b0);

        // Restart after the first data byte, then a fresh good frame.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        check_status("mid_load", 1'b0, 1'b0);
        words[0] = 16'h5555; words[1] = 16'h6666;
        load_frame(16'd2, 8'h00, 1'b0);
        check_status("restart", 1'b1, 1'b0);

        // Reset landing in the WRITE cycle aborts the load.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_write_ready", 32'(rx_ready), 32'd0);
        check("rst_write_wen",   32'(code_w_en), 32'd0);
        check("rst_write_addr",  32'(code_addr_in), 32'd0);
        check("rst_write_run",   32'(run), 32'd0);
        check("rst_write_err",   32'(err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_ready", 32'(rx_ready), 32'd0);
        words[0] = 16'hC0DE;
        load_frame(16'd1, 8'h00, 1'b0);
        check_status("after_rst", 1'b1, 1'b0);

        // Full-size program of 512 words.
        for (int i = 0; i < 512; i++) words[i] = 16'((i * 16'h0123) ^ 16'hA5C3);
        load_frame(16'h0200, 8'h00, 1'b0);
        check_status("full", 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
